// File: rtl/serial_frame_tx.sv
// serial_frame_tx: framed parallel-to-serial transmitter.
// A WIDTH-bit word accepted over a valid/ready handshake is sent on a one-wire
// line as: start bit (0), WIDTH data bits, optional even-parity bit, then
// STOP_BITS stop bits (1). Each bit is held for BIT_CYCLES clock cycles.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   parallel_in  word to send, sampled only on accept (load_valid & load_ready)
//   load_valid   source has a word on parallel_in
//   load_ready   transmitter can accept a word this cycle
//   serial_out   serial line, idles at 1
//   busy         frame in progress (start through last stop cycle)
//   done         one-cycle pulse in the final cycle of the final stop bit
module serial_frame_tx #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned BIT_CYCLES = 1,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned LSB_FIRST  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // A 1-bit counter is kept even when BIT_CYCLES = 1 so the logic stays uniform.
  localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned BW = $clog2(WIDTH + 1);

  localparam logic [CW-1:0] CycLast  = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] DataLast = BW'(WIDTH - 1);
  localparam logic [BW-1:0] StopLast = BW'(STOP_BITS - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             par_q, par_d;

  logic bit_end;
  logic last_stop;
  logic accept;

  assign bit_end   = (cyc_q == CycLast);
  assign last_stop = (state_q == StStop) && bit_end && (bit_q == StopLast);
  assign accept    = load_valid && load_ready;

  // Outputs are decodes of registered state only; load_valid never reaches them.
  always_comb begin
    load_ready = (state_q == StIdle) || last_stop;
    busy       = (state_q != StIdle);
    done       = last_stop;
    serial_out = 1'b1;
    unique case (state_q)
      StStart:  serial_out = 1'b0;
      StData:   serial_out = (LSB_FIRST != 0) ? shift_q[0] : shift_q[WIDTH-1];
      StParity: serial_out = par_q;
      default:  serial_out = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StStart;
          cyc_d   = '0;
          bit_d   = '0;
          shift_d = parallel_in;
          par_d   = ^parallel_in;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          cyc_d   = '0;
          shift_d = (LSB_FIRST != 0) ? (shift_q >> 1) : (shift_q << 1);
          if (bit_q == DataLast) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? StParity : StStop;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          cyc_d   = '0;
          bit_d   = '0;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      StStop: begin
        if (bit_end) begin
          cyc_d = '0;
          if (bit_q == StopLast) begin
            bit_d = '0;
            // Back-to-back accept skips idle and starts the next frame directly.
            if (accept) begin
              state_d = StStart;
              shift_d = parallel_in;
              par_d   = ^parallel_in;
            end else begin
              state_d = StIdle;
            end
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: three instances with different parameter sets share
// one stimulus stream. A per-instance reference model holds the expected line
// level of every remaining cycle of the frame in flight as a queue; all
// outputs are derived from that queue.
module tb_serial_frame_tx;

  localparam int NDUT = 3;
  localparam int BC[NDUT]  = '{1, 3, 2};
  localparam int PE[NDUT]  = '{1, 1, 0};
  localparam int SB[NDUT]  = '{1, 2, 1};
  localparam int LSB[NDUT] = '{1, 0, 1};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] parallel_in = 4'h0;
  logic       load_valid = 1'b0;

  logic [NDUT-1:0] lr, so, bz, dn;

  int vectors = 0;
  int miscompares = 0;

  bit exp_q0[$];
  bit exp_q1[$];
  bit exp_q2[$];

  always #5 clk = ~clk;

  serial_frame_tx #(
    .WIDTH(4), .BIT_CYCLES(1), .PARITY_EN(1), .STOP_BITS(1), .LSB_FIRST(1)
  ) u_dut0 (
    .clk(clk), .reset(reset), .parallel_in(parallel_in), .load_valid(load_valid),
    .load_ready(lr[0]), .serial_out(so[0]), .busy(bz[0]), .done(dn[0])
  );

  serial_frame_tx #(
    .WIDTH(4), .BIT_CYCLES(3), .PARITY_EN(1), .STOP_BITS(2), .LSB_FIRST(0)
  ) u_dut1 (
    .clk(clk), .reset(reset), .parallel_in(parallel_in), .load_valid(load_valid),
    .load_ready(lr[1]), .serial_out(so[1]), .busy(bz[1]), .done(dn[1])
  );

  serial_frame_tx #(
    .WIDTH(4), .BIT_CYCLES(2), .PARITY_EN(0), .STOP_BITS(1), .LSB_FIRST(1)
  ) u_dut2 (
    .clk(clk), .reset(reset), .parallel_in(parallel_in), .load_valid(load_valid),
    .load_ready(lr[2]), .serial_out(so[2]), .busy(bz[2]), .done(dn[2])
  );

  task automatic check(input string tag, input logic got, input logic exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask

  function automatic int qsize(input int k);
    case (k)
      0: return exp_q0.size();
      1: return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic bit qhead(input int k);
    case (k)
      0: return exp_q0[0];
      1: return exp_q1[0];
      default: return exp_q2[0];
    endcase
  endfunction

  task automatic qpush(input int k, input bit b);
    case (k)
      0: exp_q0.push_back(b);
      1: exp_q1.push_back(b);
      default: exp_q2.push_back(b);
    endcase
  endtask

  task automatic qpop(input int k);
    case (k)
      0: void'(exp_q0.pop_front());
      1: void'(exp_q1.pop_front());
      default: void'(exp_q2.pop_front());
    endcase
  endtask

  task automatic qclear(input int k);
    case (k)
      0: exp_q0.delete();
      1: exp_q1.delete();
      default: exp_q2.delete();
    endcase
  endtask

  // Expand a word into its line levels: start, data, parity, stops, each BC cycles.
  task automatic push_frame(input int k, input logic [3:0] w);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 4; i++) bits.push_back((LSB[k] != 0) ? w[i] : w[3-i]);
    if (PE[k] != 0) bits.push_back(w[0] ^ w[1] ^ w[2] ^ w[3]);
    for (int i = 0; i < SB[k]; i++) bits.push_back(1'b1);
    foreach (bits[i]) for (int c = 0; c < BC[k]; c++) qpush(k, bits[i]);
  endtask

  // Check the current cycle, then drive inputs for the next edge and advance the model.
  task automatic step(input logic rst, input logic lv, input logic [3:0] d);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      int  n;
      n = qsize(k);
      check($sformatf("dut%0d serial_out", k), so[k], (n > 0) ? qhead(k) : 1'b1);
      check($sformatf("dut%0d busy", k), bz[k], n > 0);
      check($sformatf("dut%0d done", k), dn[k], n == 1);
      check($sformatf("dut%0d load_ready", k), lr[k], n <= 1);
    end
    reset       = rst;
    load_valid  = lv;
    parallel_in = d;
    for (int k = 0; k < NDUT; k++) begin
      bit ready;
      ready = (qsize(k) <= 1);
      if (rst) begin
        qclear(k);
      end else begin
        if (qsize(k) > 0) qpop(k);
        if (lv && ready) push_frame(k, d);
      end
    end
  endtask

  task automatic send_and_idle(input logic [3:0] w, input int idle);
    step(1'b0, 1'b1, w);
    for (int i = 0; i < idle; i++) step(1'b0, 1'b0, 4'($urandom_range(0, 15)));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    // First step checks the post-reset idle state while reset is still high.
    step(1'b0, 1'b0, 4'h0);
    send_and_idle(4'b1011, 30);
    send_and_idle(4'b0110, 30);
    send_and_idle(4'b0001, 30);
    // Source held valid: back-to-back frames with no idle gap.
    for (int i = 0; i < 80; i++) step(1'b0, 1'b1, ((i / 8) % 2 == 0) ? 4'hA : 4'h5);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 4'h0);
    // Reset asserted while the default instance sends data bit 2, held two cycles.
    step(1'b0, 1'b1, 4'b1101);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b1, 4'h3);
    send_and_idle(4'b1001, 30);
    // Random traffic with occasional resets.
    for (int i = 0; i < 2500; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1),
           4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 4'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Framed parallel-to-serial transmitter: accepts a WIDTH-bit word over a valid/ready handshake and drives it onto a one-wire serial line as start bit, data bits, optional even-parity bit and stop bit(s). It is the transmit end of the serial link whose receive side is the universal shift register used in serial-in/parallel-out mode. It also feeds the bit-level framing checker planned for that register.

## Interface
- WIDTH, 4: data bits per frame (≥1)
- BIT_CYCLES, 1: clock cycles each bit is held on the line (≥1)
- PARITY_EN, 1: 1 = append even-parity bit after data; 0 = no parity bit
- STOP_BITS, 1: number of stop bits (1 or 2)
- LSB_FIRST, 1: 1 = data bit 0 sent first; 0 = bit WIDTH-1 first
- clk, input, 1, rising-edge clock
- reset, input, 1, synchronous, active-high; one clock, reset sampled only on posedge clk
- parallel_in, input, WIDTH, word to send; sampled only on accept
- load_valid, input, 1, source has a word on parallel_in
- load_ready, output, 1, transmitter can accept a word this cycle
- serial_out, output, 1, serial line; idle level 1
- busy, output, 1, frame in progress (START through last STOP cycle)
- done, output, 1, one-cycle pulse during final cycle of final stop bit

## Operation
- Accept = load_valid & load_ready at a posedge; parallel_in latched into internal shift register, parity computed from latched value (XOR of all bits).
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: serial_out=1, busy=0, load_ready=1. On accept -> START.
- START: serial_out=0 for BIT_CYCLES cycles -> DATA.
- DATA: shift out WIDTH bits, each BIT_CYCLES cycles, order per LSB_FIRST; bit counter 0..WIDTH-1 -> PARITY if PARITY_EN else STOP.
- PARITY: serial_out = XOR of data bits (even parity: total ones incl. parity is even), BIT_CYCLES cycles -> STOP.
- STOP: serial_out=1 for STOP_BITS×BIT_CYCLES cycles. In its final cycle: done=1, load_ready=1. Accept there -> START next cycle (back-to-back, no idle gap); else -> IDLE.
- load_ready=0 in all other cycles; load_valid ignored then, parallel_in may change freely.
- Bit-cycle counter width clog2(BIT_CYCLES), bit counter width clog2(WIDTH+1); both wrap to 0 on each state change.
- serial_out, busy, done, load_ready are register-driven or pure state decodes; no combinational path from load_valid/parallel_in to serial_out.

## Timing
- Reset values: serial_out=1, busy=0, done=0, load_ready=1 (after reset released), state=IDLE, counters=0, shift register=0.
- reset asserted at posedge: next cycle IDLE regardless of state; frame in flight abandoned (line returns to 1 immediately, no stop bits); accept in same cycle as reset discarded.
- Accept at edge N: serial_out=0 from cycle N+1.
- Frame length L = (1+WIDTH+PARITY_EN+STOP_BITS)×BIT_CYCLES cycles; busy=1 exactly those L cycles.
- Back-to-back accept in final stop cycle: next frame's start bit in the immediately following cycle; busy stays 1; done still pulses.
- Sustained throughput: one word per L cycles.

## Test plan
- Reset: hold reset 2 cycles mid-anything -> serial_out=1, busy=0, done=0, load_ready=1 cycle after release.
- Default params, parallel_in=4'b1011 accepted -> serial_out sequence 0,1,1,0,1,1,1 (start, d0..d3, parity=1, stop); busy 7 cycles; done on 7th.
- PARITY_EN=1, parallel_in=4'b0110 -> parity bit 0; LSB_FIRST=0 with 4'b1011 -> data bits 1,0,1,1.
- BIT_CYCLES=3, STOP_BITS=2, 4'b0001 -> each bit held 3 cycles, frame 24 cycles, done only on cycle 24.
- load_valid held high with 4'hA then 4'h5 -> second start bit directly after first stop bit, no idle cycle; load_ready high only in final stop cycle.
- reset asserted during DATA bit 2 -> serial_out=1 next cycle, no done pulse, next accepted word sent as a complete frame.
